// File: rtl/axi_lite_uart_master.sv
// AXI4-Lite master: turns single-beat register requests into AXI-Lite
// write/read transactions, one outstanding at a time, and returns the
// slave's response on a valid/ready result port. A sticky timeout flag
// reports any AXI phase that waits TIMEOUT_CYCLES or more.
//
// Handshake rule on every channel: a transfer happens on the rising edge
// where valid and ready are both high; a valid, once raised, stays high
// with its payload stable until that edge.
module axi_lite_uart_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 4,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                          m_axi_aclk,
    input  logic                          m_axi_areset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]                   cmd_wdata,
    input  logic [3:0]                    cmd_wstrb,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic                          rsp_write,
    output logic [31:0]                   rsp_rdata,
    output logic [1:0]                    rsp_resp,
    output logic                          timeout_err,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [2:0]                    m_axi_awprot,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    output logic [31:0]                   m_axi_wdata,
    output logic [3:0]                    m_axi_wstrb,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready,
    input  logic [1:0]                    m_axi_bresp,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [2:0]                    m_axi_arprot,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready,
    input  logic [31:0]                   m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp
);

    typedef enum logic [2:0] {
        IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP
    } state_t;

    // Counter wide enough to hold TIMEOUT_CYCLES; a zero limit never counts.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t                          state_q, state_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]                     wdata_q;
    logic [3:0]                      wstrb_q;
    logic                            awvalid_q, wvalid_q, arvalid_q;
    logic                            rsp_write_q;
    logic [31:0]                     rsp_rdata_q;
    logic [1:0]                      rsp_resp_q;
    logic [CNT_W-1:0]                cnt_q;
    logic                            timeout_q;
    logic                            aw_fin, w_fin, waiting;

    // A channel is finished once its valid has dropped or is handshaking now.
    assign aw_fin  = !awvalid_q || m_axi_awready;
    assign w_fin   = !wvalid_q  || m_axi_wready;
    assign waiting = (state_q == WR_ADDR_DATA) || (state_q == WR_RESP) ||
                     (state_q == RD_ADDR)      || (state_q == RD_DATA);

    // State register.
    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) state_q <= IDLE;
        else              state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:         if (cmd_valid) state_d = cmd_write ? WR_ADDR_DATA : RD_ADDR;
            WR_ADDR_DATA: if (aw_fin && w_fin) state_d = WR_RESP;
            WR_RESP:      if (m_axi_bvalid) state_d = RESP;
            RD_ADDR:      if (m_axi_arready) state_d = RD_DATA;
            RD_DATA:      if (m_axi_rvalid) state_d = RESP;
            RESP:         if (rsp_ready) state_d = IDLE;
            default:      state_d = IDLE;
        endcase
    end

    // Request capture, AXI valid flags and response capture.
    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (cmd_valid) begin
                    addr_q    <= cmd_addr;
                    wdata_q   <= cmd_wdata;
                    wstrb_q   <= cmd_wstrb;
                    awvalid_q <= cmd_write;
                    wvalid_q  <= cmd_write;
                    arvalid_q <= !cmd_write;
                end
                WR_ADDR_DATA: begin
                    if (m_axi_awready) awvalid_q <= 1'b0;
                    if (m_axi_wready)  wvalid_q  <= 1'b0;
                end
                WR_RESP: if (m_axi_bvalid) begin
                    rsp_resp_q  <= m_axi_bresp;
                    rsp_rdata_q <= '0;
                    rsp_write_q <= 1'b1;
                end
                RD_ADDR: if (m_axi_arready) arvalid_q <= 1'b0;
                RD_DATA: if (m_axi_rvalid) begin
                    rsp_resp_q  <= m_axi_rresp;
                    rsp_rdata_q <= m_axi_rdata;
                    rsp_write_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Per-phase wait counter (saturating) and the sticky timeout flag.
    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else if (state_d != state_q) begin
            cnt_q <= '0;
        end else if (waiting && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) timeout_q <= 1'b1;
        end
    end

    assign cmd_ready     = (state_q == IDLE);
    assign rsp_valid     = (state_q == RESP);
    assign rsp_write     = rsp_write_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign timeout_err   = timeout_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_bready  = (state_q == WR_RESP);
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_rready  = (state_q == RD_DATA);

endmodule

// File: tb/tb_axi_lite_uart_master.sv
// Bench for axi_lite_uart_master: directed and random register requests,
// a scripted AXI slave, and a result monitor with an expected queue.
module tb_axi_lite_uart_master;
  localparam int AW = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_wdata;
  logic [3:0]    cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_write;
  logic [31:0]   rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          timeout_err;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;

  axi_lite_uart_master #(.C_M_AXI_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .m_axi_aclk(clk), .m_axi_areset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .timeout_err(timeout_err),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr),
    .m_axi_awprot(awprot), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_bvalid(bvalid),
    .m_axi_bready(bready), .m_axi_bresp(bresp), .m_axi_arvalid(arvalid),
    .m_axi_arready(arready), .m_axi_araddr(araddr), .m_axi_arprot(arprot),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata),
    .m_axi_rresp(rresp)
  );

  typedef struct {
    bit            write;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic [31:0]   rdata;
    logic [1:0]    resp;
    int            aw_dly;
    int            w_dly;
    int            b_dly;
    int            ar_dly;
    int            r_dly;
  } txn_t;

  txn_t        plan_q[$];
  logic [34:0] exp_q[$];
  int          hold_q[$];
  int          lat_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc_n = 0;
  bit          abort_slave = 1'b0;
  bit          mon_busy = 1'b0;

  // ---------------- clock / reset ----------------
  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc_n++;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event (cycle %0d)", name, cyc_n);
  endtask

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic txn_t mk_wr(input logic [AW-1:0] a, input logic [31:0] d,
                                 input logic [3:0] s, input logic [1:0] r,
                                 input int awd, input int wd, input int bd);
    txn_t t;
    t.write = 1'b1; t.addr = a; t.wdata = d; t.wstrb = s; t.rdata = '0; t.resp = r;
    t.aw_dly = awd; t.w_dly = wd; t.b_dly = bd; t.ar_dly = 0; t.r_dly = 0;
    return t;
  endfunction

  function automatic txn_t mk_rd(input logic [AW-1:0] a, input logic [31:0] d,
                                 input logic [1:0] r, input int ard, input int rd);
    txn_t t;
    t.write = 1'b0; t.addr = a; t.wdata = '0; t.wstrb = '0; t.rdata = d; t.resp = r;
    t.aw_dly = 0; t.w_dly = 0; t.b_dly = 0; t.ar_dly = ard; t.r_dly = rd;
    return t;
  endfunction

  // ---------------- driver ----------------
  // Waits for cmd_ready (driving junk requests meanwhile, which must be
  // ignored), presents the request and records what the result must be.
  // Result cycle: accept + 1 address phase + waits + 1 response phase + 1.
  task automatic issue(input txn_t t, input int hold, output int acc);
    int n;
    n = 0;
    acc = -1;
    @(negedge clk);
    while (!cmd_ready) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_write = 1'($urandom_range(0, 1));
      cmd_addr  = AW'($urandom);
      cmd_wdata = $urandom;
      cmd_wstrb = 4'($urandom);
      n++;
      if (n > 500) begin
        fail("cmd_ready wait");
        cmd_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b1;
    cmd_write = t.write;
    cmd_addr  = t.addr;
    cmd_wdata = t.wdata;
    cmd_wstrb = t.wstrb;
    acc = cyc_n;
    plan_q.push_back(t);
    exp_q.push_back({t.write, (t.write ? 32'h0 : t.rdata), t.resp});
    hold_q.push_back(hold);
    if (t.write) lat_q.push_back(acc + 3 + max2(t.aw_dly, t.w_dly) + t.b_dly);
    else         lat_q.push_back(acc + 3 + t.ar_dly + t.r_dly);
    @(negedge clk);
    chk("cmd_ready low after accept", cmd_ready, 1'b0);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) fail("drain responses");
    repeat (2) @(negedge clk);
  endtask

  // ---------------- AXI slave ----------------
  task automatic slave_write();
    txn_t t;
    int   cyc;
    bit   aw_done, w_done, hs;
    if (plan_q.size() == 0) begin
      fail("unexpected write issued");
      return;
    end
    t = plan_q.pop_front();
    chk("write channels used for write cmd", 1'b1, t.write);
    aw_done = 1'b0; w_done = 1'b0; cyc = 0;
    while (!(aw_done && w_done)) begin
      if (cyc > 0) begin
        @(negedge clk);
        if (abort_slave) begin awready = 1'b0; wready = 1'b0; return; end
      end
      if (cyc > 600) begin fail("aw/w handshake"); awready = 1'b0; wready = 1'b0; return; end
      chk("arvalid during write", arvalid, 1'b0);
      chk("bready during aw/w", bready, 1'b0);
      if (!aw_done) begin
        chk("awvalid held", awvalid, 1'b1);
        chk("awaddr", awaddr, t.addr);
      end else chk("awvalid dropped", awvalid, 1'b0);
      if (!w_done) begin
        chk("wvalid held", wvalid, 1'b1);
        chk("wdata", wdata, t.wdata);
        chk("wstrb", wstrb, t.wstrb);
      end else chk("wvalid dropped", wvalid, 1'b0);
      awready = !aw_done && (cyc >= t.aw_dly);
      wready  = !w_done && (cyc >= t.w_dly);
      if (awready && awvalid) aw_done = 1'b1;
      if (wready && wvalid)   w_done = 1'b1;
      cyc++;
    end
    cyc = 0;
    hs = 1'b0;
    while (!hs) begin
      @(negedge clk);
      awready = 1'b0;
      wready  = 1'b0;
      if (abort_slave) begin bvalid = 1'b0; return; end
      if (cyc > 600) begin fail("b handshake"); bvalid = 1'b0; return; end
      chk("awvalid after aw/w", awvalid, 1'b0);
      chk("wvalid after aw/w", wvalid, 1'b0);
      chk("bready in response wait", bready, 1'b1);
      bvalid = (cyc >= t.b_dly);
      bresp  = bvalid ? t.resp : 2'($urandom);
      hs = bvalid && bready;
      cyc++;
    end
  endtask

  task automatic slave_read();
    txn_t t;
    int   cyc;
    bit   hs;
    if (plan_q.size() == 0) begin
      fail("unexpected read issued");
      return;
    end
    t = plan_q.pop_front();
    chk("read channel used for read cmd", 1'b0, t.write);
    cyc = 0;
    hs = 1'b0;
    while (!hs) begin
      if (cyc > 0) begin
        @(negedge clk);
        if (abort_slave) begin arready = 1'b0; return; end
      end
      if (cyc > 600) begin fail("ar handshake"); arready = 1'b0; return; end
      chk("awvalid during read", awvalid, 1'b0);
      chk("wvalid during read", wvalid, 1'b0);
      chk("rready during ar", rready, 1'b0);
      chk("arvalid held", arvalid, 1'b1);
      chk("araddr", araddr, t.addr);
      arready = (cyc >= t.ar_dly);
      hs = arready && arvalid;
      cyc++;
    end
    cyc = 0;
    hs = 1'b0;
    while (!hs) begin
      @(negedge clk);
      arready = 1'b0;
      if (abort_slave) begin rvalid = 1'b0; return; end
      if (cyc > 600) begin fail("r handshake"); rvalid = 1'b0; return; end
      chk("arvalid after ar", arvalid, 1'b0);
      chk("rready in data wait", rready, 1'b1);
      rvalid = (cyc >= t.r_dly);
      rdata  = rvalid ? t.rdata : $urandom;
      rresp  = rvalid ? t.resp : 2'($urandom);
      hs = rvalid && rready;
      cyc++;
    end
  endtask

  initial begin
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
    forever begin
      @(negedge clk);
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0; rvalid = 1'b0;
      if (!(abort_slave || rst)) begin
        chk("bready idle", bready, 1'b0);
        chk("rready idle", rready, 1'b0);
        if (awvalid || wvalid) slave_write();
        else if (arvalid)      slave_read();
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [34:0] first, cur, exp;
    int          held, hold, lat;
    bit          seen_done;
    held = 0; hold = 0; lat = 0; seen_done = 1'b0; first = '0;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_busy = 1'b0;
        seen_done = 1'b0;
        rsp_ready = 1'b0;
      end else begin
        cur = {rsp_write, rsp_rdata, rsp_resp};
        if (seen_done) begin
          chk("cmd_ready one cycle after rsp", cmd_ready, 1'b1);
          seen_done = 1'b0;
        end
        if (rsp_valid) begin
          chk("cmd_ready low while rsp pending", cmd_ready, 1'b0);
          if (!mon_busy) begin
            if (exp_q.size() == 0) begin
              fail("unexpected rsp_valid");
              rsp_ready = 1'b1;
            end else begin
              mon_busy = 1'b1;
              first = cur;
              held = 0;
              hold = hold_q.pop_front();
              lat = lat_q.pop_front();
              chk("rsp_valid cycle", cyc_n, lat);
            end
          end else begin
            chk("rsp stable while stalled", cur, first);
          end
          if (mon_busy) begin
            rsp_ready = (held >= hold);
            if (rsp_ready) begin
              exp = exp_q.pop_front();
              chk("rsp write/rdata/resp", cur, exp);
              mon_busy = 1'b0;
              seen_done = 1'b1;
            end
            held++;
          end
        end else begin
          rsp_ready = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    txn_t t;
    int   acc;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset cmd_ready", cmd_ready, 1'b1);
    chk("reset awvalid", awvalid, 1'b0);
    chk("reset wvalid", wvalid, 1'b0);
    chk("reset arvalid", arvalid, 1'b0);
    chk("reset bready", bready, 1'b0);
    chk("reset rready", rready, 1'b0);
    chk("reset rsp_valid", rsp_valid, 1'b0);
    chk("reset rsp fields", {rsp_write, rsp_rdata, rsp_resp}, 35'h0);
    chk("reset timeout_err", timeout_err, 1'b0);
    chk("reset addr/data", {awaddr, araddr, wdata, wstrb}, '0);
    chk("prot constant", {awprot, arprot}, 6'h0);
    rst = 1'b0;

    // Zero-wait write: result in cycle 3.
    issue(mk_wr(4'h4, 32'h0000_0055, 4'hF, 2'b00, 0, 0, 0), 0, acc);
    // W ready 3 cycles ahead of AW.
    issue(mk_wr(4'h4, 32'h1234_5678, 4'h3, 2'b00, 3, 0, 1), 1, acc);
    // Read with 5 data wait cycles.
    issue(mk_rd(4'h8, 32'h0000_00A5, 2'b00, 0, 5), 0, acc);
    // SLVERR read, result stalled 4 cycles.
    issue(mk_rd(4'hC, 32'hDEAD_BEEF, 2'b10, 1, 0), 4, acc);
    // Back-to-back write then read.
    issue(mk_wr(4'h0, 32'hCAFE_0001, 4'hF, 2'b00, 0, 0, 0), 0, acc);
    issue(mk_rd(4'h0, 32'hCAFE_0001, 2'b00, 0, 0), 0, acc);
    issue(mk_wr(4'h8, 32'h0BAD_F00D, 4'h5, 2'b11, 0, 2, 0), 0, acc);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1)
        t = mk_wr(AW'($urandom), $urandom, 4'($urandom), 2'($urandom_range(0, 3)),
                  int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
      else
        t = mk_rd(AW'($urandom), $urandom, 2'($urandom_range(0, 3)),
                  int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
      issue(t, int'($urandom_range(0, 3)), acc);
    end
    drain();
    chk("no timeout on short waits", timeout_err, 1'b0);

    // Slave never accepts AW: timeout after 16 cycles in the address phase.
    issue(mk_wr(4'h4, 32'h0000_0077, 4'hF, 2'b00, 100000, 0, 0), 0, acc);
    while (cyc_n < acc + TO) @(negedge clk);
    chk("timeout_err before limit", timeout_err, 1'b0);
    @(negedge clk);
    chk("timeout_err at limit", timeout_err, 1'b1);
    chk("awvalid held on timeout", awvalid, 1'b1);
    repeat (4) @(negedge clk);
    chk("timeout_err sticky", timeout_err, 1'b1);
    chk("awvalid still held", awvalid, 1'b1);
    @(posedge clk);
    #2;
    abort_slave = 1'b1;
    rst = 1'b1;
    #1;
    chk("async reset awvalid", awvalid, 1'b0);
    chk("async reset wvalid", wvalid, 1'b0);
    chk("async reset arvalid", arvalid, 1'b0);
    chk("async reset cmd_ready", cmd_ready, 1'b1);
    chk("async reset timeout_err", timeout_err, 1'b0);
    plan_q.delete();
    exp_q.delete();
    hold_q.delete();
    lat_q.delete();
    repeat (2) @(negedge clk);
    abort_slave = 1'b0;
    rst = 1'b0;

    // Recovery after reset.
    issue(mk_rd(4'h4, 32'h5A5A_0F0F, 2'b01, 2, 1), 1, acc);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
